// File: rtl/mmu_acc_drain.sv
// Accumulates MMU partial-sum rows across K tiles into a row buffer, then
// drains each row (shift, optional ReLU, saturate) over a valid/ready port.
module mmu_acc_drain #(
    parameter int unsigned bit_width = 16,
    parameter int unsigned acc_width = 64,
    parameter int unsigned size      = 32,
    parameter int unsigned depth     = 32,
    parameter int unsigned row_bits  = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [row_bits-1:0]           num_rows,
    input  logic [7:0]                    k_tiles,
    input  logic                          relu_en,
    input  logic [5:0]                    shift,
    input  logic                          acc_valid,
    input  logic [acc_width*size-1:0]     acc_in,
    output logic                          busy,
    output logic                          done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [bit_width*size-1:0]     out_data,
    output logic [row_bits-1:0]           out_row
);

    localparam int unsigned ACC_VEC_W = acc_width * size;
    localparam int unsigned OUT_VEC_W = bit_width * size;
    localparam logic signed [acc_width-1:0] SAT_MAX =
        {{(acc_width-bit_width+1){1'b0}}, {(bit_width-1){1'b1}}};
    localparam logic signed [acc_width-1:0] SAT_MIN =
        {{(acc_width-bit_width+1){1'b1}}, {(bit_width-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [row_bits-1:0]    row_ptr_q, row_ptr_d;
    logic [7:0]             tile_cnt_q, tile_cnt_d;
    logic [row_bits-1:0]    num_rows_q, num_rows_d;
    logic [7:0]             k_tiles_q, k_tiles_d;
    logic                   relu_q, relu_d;
    logic [5:0]             shift_q, shift_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   out_valid_q, out_valid_d;
    logic [OUT_VEC_W-1:0]   out_data_q, out_data_d;
    logic [row_bits-1:0]    out_row_q, out_row_d;

    logic [ACC_VEC_W-1:0]   row_buf_q [depth];
    logic [ACC_VEC_W-1:0]   cur_row, new_row, src_row;
    logic [OUT_VEC_W-1:0]   pp_row;
    logic [row_bits-1:0]    rd_idx;
    logic                   buf_we, fwd;

    function automatic logic [bit_width-1:0] post_proc(
        input logic [acc_width-1:0] a,
        input logic [5:0]           sh,
        input logic                 relu
    );
        logic signed [acc_width-1:0] v;
        v = $signed(a) >>> sh;
        if (relu && v < 0) v = '0;
        if (v > SAT_MAX)      v = SAT_MAX;
        else if (v < SAT_MIN) v = SAT_MIN;
        return v[bit_width-1:0];
    endfunction

    // Lane-wise overwrite (first tile) or wrapping accumulate
    always_comb begin
        cur_row = row_buf_q[row_ptr_q];
        new_row = '0;
        for (int unsigned i = 0; i < size; i++) begin
            if (tile_cnt_q == 8'd0)
                new_row[i*acc_width +: acc_width] = acc_in[i*acc_width +: acc_width];
            else
                new_row[i*acc_width +: acc_width] = cur_row[i*acc_width +: acc_width]
                                                  + acc_in[i*acc_width +: acc_width];
        end
    end

    // Row 0 is read while its final value may still be in flight (single-row tile)
    always_comb begin
        rd_idx  = (state_q == ACCUM) ? '0 : row_bits'(out_row_q + 1'b1);
        fwd     = (state_q == ACCUM) && acc_valid && (row_ptr_q == rd_idx);
        src_row = fwd ? new_row : row_buf_q[rd_idx];
        pp_row  = '0;
        for (int unsigned i = 0; i < size; i++)
            pp_row[i*bit_width +: bit_width] =
                post_proc(src_row[i*acc_width +: acc_width], shift_q, relu_q);
    end

    always_comb begin
        state_d     = state_q;
        row_ptr_d   = row_ptr_q;
        tile_cnt_d  = tile_cnt_q;
        num_rows_d  = num_rows_q;
        k_tiles_d   = k_tiles_q;
        relu_d      = relu_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        buf_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_rows_d = num_rows;
                    k_tiles_d  = k_tiles;
                    relu_d     = relu_en;
                    shift_d    = shift;
                    row_ptr_d  = '0;
                    tile_cnt_d = '0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                if (acc_valid) begin
                    buf_we = 1'b1;
                    if (row_ptr_q == num_rows_q) begin
                        row_ptr_d  = '0;
                        tile_cnt_d = tile_cnt_q + 8'd1;
                        if (tile_cnt_q == k_tiles_q) begin
                            state_d     = DRAIN;
                            out_valid_d = 1'b1;
                            out_data_d  = pp_row;
                            out_row_d   = '0;
                        end
                    end else begin
                        row_ptr_d = row_bits'(row_ptr_q + 1'b1);
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (out_row_q == num_rows_q) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end else begin
                        out_row_d  = rd_idx;
                        out_data_d = pp_row;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_ptr_q   <= '0;
            tile_cnt_q  <= '0;
            num_rows_q  <= '0;
            k_tiles_q   <= '0;
            relu_q      <= 1'b0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_ptr_q   <= row_ptr_d;
            tile_cnt_q  <= tile_cnt_d;
            num_rows_q  <= num_rows_d;
            k_tiles_q   <= k_tiles_d;
            relu_q      <= relu_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
        end
    end

    // Row storage carries no reset; contents are rewritten by the first tile
    always_ff @(posedge clk) begin
        if (buf_we) row_buf_q[row_ptr_q] <= new_row;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;

endmodule
